// File: rtl/gate_mem_cfg_ctrl.sv
// Endpoint-table configuration sequencer: host writes land in a shadow table, and a
// commit drains DMA traffic, validates every endpoint and swaps the table onto ep_ctrl.
module gate_mem_cfg_ctrl #(
    parameter int N_ENDPOINTS   = 4,
    parameter int OUTS_BITS     = 8,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              cfg_wr_en,
    input  logic [$clog2(4*N_ENDPOINTS)-1:0]  cfg_wr_addr,
    input  logic [31:0]                       cfg_wr_data,
    output logic                              cfg_wr_rej,
    input  logic                              cmd_commit,
    input  logic                              req_issue,
    input  logic                              req_done,
    output logic                              hold,
    output logic                              busy,
    output logic                              commit_done,
    output logic                              cfg_err,
    output logic [1:0]                        err_code,
    output logic [$clog2(N_ENDPOINTS):0]      err_ep,
    output logic [OUTS_BITS-1:0]              outstanding,
    output logic [99*N_ENDPOINTS-1:0]         ep_ctrl
);

    localparam int AW = $clog2(4*N_ENDPOINTS);
    localparam int EW = $clog2(N_ENDPOINTS) + 1;
    localparam int IW = (N_ENDPOINTS > 1) ? $clog2(N_ENDPOINTS) : 1;
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        VALIDATE,
        COMMIT,
        ERROR
    } state_t;

    state_t                    state_reg;
    logic [IW-1:0]             idx_reg;
    logic [TW-1:0]             timer_reg;
    logic [99*N_ENDPOINTS-1:0] shadow_flat;
    logic [N_ENDPOINTS-1:0]    bad_vec;
    logic                      in_range;
    logic                      wr_ok;

    assign in_range = ({1'b0, cfg_wr_addr} < (AW+1)'(4*N_ENDPOINTS));
    assign wr_ok    = cfg_wr_en && in_range && !busy;

    generate
        for (genvar gi = 0; gi < N_ENDPOINTS; gi++) begin : g_ep
            logic [47:0] base_reg;
            logic [47:0] bound_reg;
            logic [1:0]  access_reg;
            logic        valid_reg;
            logic        hit;

            assign hit = wr_ok && ((cfg_wr_addr >> 2) == AW'(gi));

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    base_reg   <= '0;
                    bound_reg  <= '0;
                    access_reg <= '0;
                    valid_reg  <= 1'b0;
                end else if (hit) begin
                    case (cfg_wr_addr[1:0])
                        2'd0: base_reg[31:0]   <= cfg_wr_data;
                        2'd1: base_reg[47:32]  <= cfg_wr_data[15:0];
                        2'd2: bound_reg[31:0]  <= cfg_wr_data;
                        default: begin
                            bound_reg[47:32] <= cfg_wr_data[15:0];
                            access_reg       <= cfg_wr_data[17:16];
                            valid_reg        <= cfg_wr_data[18];
                        end
                    endcase
                end
            end

            assign shadow_flat[gi*99 +: 99] = {valid_reg, access_reg, bound_reg, base_reg};
            // Invalid endpoints are never range-checked.
            assign bad_vec[gi] = valid_reg && (base_reg > bound_reg);
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cfg_wr_rej <= 1'b0;
        end else begin
            cfg_wr_rej <= cfg_wr_en && in_range && busy;
        end
    end

    // Saturating in-flight counter; simultaneous issue and done cancel out.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            outstanding <= '0;
        end else if (req_issue && !req_done && (outstanding != '1)) begin
            outstanding <= outstanding + 1'b1;
        end else if (req_done && !req_issue && (outstanding != '0)) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            timer_reg   <= '0;
            busy        <= 1'b0;
            hold        <= 1'b0;
            commit_done <= 1'b0;
            cfg_err     <= 1'b0;
            err_code    <= 2'b00;
            err_ep      <= '0;
            ep_ctrl     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    commit_done <= 1'b0;
                    if (cmd_commit) begin
                        state_reg <= DRAIN;
                        busy      <= 1'b1;
                        hold      <= 1'b1;
                        timer_reg <= '0;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state_reg <= VALIDATE;
                        idx_reg   <= '0;
                    end else if (timer_reg == TW'(DRAIN_TIMEOUT - 1)) begin
                        state_reg   <= ERROR;
                        err_code    <= 2'b10;
                        err_ep      <= '1;
                        commit_done <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                VALIDATE: begin
                    if (bad_vec[idx_reg]) begin
                        state_reg   <= ERROR;
                        err_code    <= 2'b01;
                        err_ep      <= EW'(idx_reg);
                        commit_done <= 1'b1;
                    end else if (idx_reg == IW'(N_ENDPOINTS - 1)) begin
                        state_reg   <= COMMIT;
                        commit_done <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                COMMIT: begin
                    // Whole table swaps on one edge so the gateway never sees a mix.
                    ep_ctrl     <= shadow_flat;
                    cfg_err     <= 1'b0;
                    err_code    <= 2'b00;
                    err_ep      <= '0;
                    commit_done <= 1'b0;
                    busy        <= 1'b0;
                    hold        <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    cfg_err     <= 1'b1;
                    commit_done <= 1'b0;
                    busy        <= 1'b0;
                    hold        <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_mem_cfg_ctrl.sv
// Self-checking bench for gate_mem_cfg_ctrl: directed table, multi-cycle sequences and
// randomized commits against a table-level reference model.
module tb_gate_mem_cfg_ctrl;

    localparam int N  = 4;
    localparam int OB = 8;
    localparam int DT = 16;
    localparam int W  = 99 * N;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cfg_wr_en = 1'b0;
    logic [3:0]    cfg_wr_addr = '0;
    logic [31:0]   cfg_wr_data = '0;
    logic          cfg_wr_rej;
    logic          cmd_commit = 1'b0;
    logic          req_issue = 1'b0;
    logic          req_done = 1'b0;
    logic          hold;
    logic          busy;
    logic          commit_done;
    logic          cfg_err;
    logic [1:0]    err_code;
    logic [2:0]    err_ep;
    logic [OB-1:0] outstanding;
    logic [W-1:0]  ep_ctrl;

    gate_mem_cfg_ctrl #(
        .N_ENDPOINTS  (N),
        .OUTS_BITS    (OB),
        .DRAIN_TIMEOUT(DT)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data),
        .cfg_wr_rej (cfg_wr_rej),
        .cmd_commit (cmd_commit),
        .req_issue  (req_issue),
        .req_done   (req_done),
        .hold       (hold),
        .busy       (busy),
        .commit_done(commit_done),
        .cfg_err    (cfg_err),
        .err_code   (err_code),
        .err_ep     (err_ep),
        .outstanding(outstanding),
        .ep_ctrl    (ep_ctrl)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: endpoint records, active table image, in-flight count.
    logic [47:0]  m_base  [N];
    logic [47:0]  m_bound [N];
    logic [1:0]   m_acc   [N];
    logic         m_val   [N];
    logic [W-1:0] m_active;
    int           m_out;

    typedef struct {
        int          ep;
        logic [47:0] base;
        logic [47:0] bound;
        logic [1:0]  acc;
        logic        val;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [2:0]  exp_ep;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] shadow_image();
        logic [W-1:0] img;
        img = '0;
        for (int i = 0; i < N; i++) img[i*99 +: 99] = {m_val[i], m_acc[i], m_bound[i], m_base[i]};
        return img;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_base[i] = '0; m_bound[i] = '0; m_acc[i] = '0; m_val[i] = 1'b0;
        end
        m_active = '0;
        m_out = 0;
    endtask

    task automatic tick();
        if (!aresetn) m_out = 0;
        else if (req_issue && !req_done && m_out < (1 << OB) - 1) m_out++;
        else if (req_done && !req_issue && m_out > 0) m_out--;
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'(addr); cfg_wr_data = data;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    // Program an endpoint while idle, with junk in the ignored data bits.
    task automatic prog(input int ep, input logic [47:0] base, input logic [47:0] bound,
                        input logic [1:0] acc, input logic val);
        logic [31:0] junk;
        junk = $urandom();
        wr(ep*4 + 0, base[31:0]);
        wr(ep*4 + 1, {junk[15:0], base[47:32]});
        wr(ep*4 + 2, bound[31:0]);
        wr(ep*4 + 3, {junk[31:19], val, acc, bound[47:32]});
        m_base[ep] = base; m_bound[ep] = bound; m_acc[ep] = acc; m_val[ep] = val;
    endtask

    task automatic predict(output logic e, output logic [1:0] code, output logic [2:0] ep);
        e = 1'b0; code = 2'b00; ep = 3'd0;
        if (m_out > 0) begin
            e = 1'b1; code = 2'b10; ep = 3'b111;
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (m_val[i] && m_base[i] > m_bound[i]) begin
                    e = 1'b1; code = 2'b01; ep = 3'(i);
                end
        end
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (commit_done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        if (cyc >= 200) chk($sformatf("%s.done_timeout", tag), commit_done, 1);
    endtask

    task automatic commit_run(input string tag, input logic e, input logic [1:0] code,
                              input logic [2:0] ep);
        int cyc;
        cmd_commit = 1'b1;
        tick();
        cmd_commit = 1'b0;
        wait_done(tag, cyc);
        tick();
        if (!e) m_active = shadow_image();
        chk($sformatf("%s.pulse_once", tag), commit_done, 0);
        chk($sformatf("%s.busy", tag), {busy, hold}, 0);
        chk($sformatf("%s.err", tag), {cfg_err, err_code, err_ep}, {e, code, ep});
        chk($sformatf("%s.ep_ctrl", tag), ep_ctrl, m_active);
        $display("[TB] %s: err=%0d code=%0d ep=%0d", tag, cfg_err, err_code, err_ep);
    endtask

    task automatic chk_zero(input string tag);
        chk($sformatf("%s.ctl", tag),
            {cfg_wr_rej, hold, busy, commit_done, cfg_err, err_code, err_ep, outstanding}, 0);
        chk($sformatf("%s.ep_ctrl", tag), ep_ctrl, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            cyc;
        logic          seen;
        logic [98:0]   exp99;
        logic          pe;
        logic [1:0]    pc;
        logic [2:0]    pep;
        logic [63:0]   r;
        logic [47:0]   b;
        logic [47:0]   d;

        vecs[0]  = '{0, 48'h1000, 48'h1FFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0};
        vecs[1]  = '{2, 48'h5000, 48'h4000, 2'b01, 1'b1, 1'b1, 2'b01, 3'd2};
        vecs[2]  = '{2, 48'h5000, 48'h5000, 2'b01, 1'b1, 1'b0, 2'b00, 3'd0};
        vecs[3]  = '{3, 48'h8000_0000_0001, 48'h8000_0000_0000, 2'b10, 1'b0, 1'b0, 2'b00, 3'd0};
        vecs[4]  = '{1, 48'hFFFF_FFFF_FFFF, 48'h0, 2'b01, 1'b1, 1'b1, 2'b01, 3'd1};
        vecs[5]  = '{1, 48'h0, 48'hFFFF_FFFF_FFFF, 2'b01, 1'b1, 1'b0, 2'b00, 3'd0};
        vecs[6]  = '{3, 48'h8000_0000_0001, 48'h8000_0000_0000, 2'b10, 1'b1, 1'b1, 2'b01, 3'd3};
        vecs[7]  = '{3, 48'h0001_0000_0000, 48'h0001_0000_0000, 2'b10, 1'b1, 1'b0, 2'b00, 3'd0};
        vecs[8]  = '{3, 48'h9, 48'h8, 2'b00, 1'b1, 1'b1, 2'b01, 3'd3};
        vecs[9]  = '{0, 48'h2, 48'h1, 2'b11, 1'b1, 1'b1, 2'b01, 3'd0};
        vecs[10] = '{0, 48'h1, 48'h2, 2'b11, 1'b1, 1'b1, 2'b01, 3'd3};
        vecs[11] = '{3, 48'h9, 48'h8, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0};

        model_reset();
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
        chk_zero("reset");

        // Commit latency with an idle gateway.
        prog(0, 48'h1000, 48'h1FFF, 2'b11, 1'b1);
        cmd_commit = 1'b1;
        tick();
        cmd_commit = 1'b0;
        chk("lat.busy", {busy, hold}, 2'b11);
        for (int c = 1; c < 7; c++) begin
            if (c == 5) chk("lat.done_early", commit_done, 0);
            if (c == 6) begin
                chk("lat.done", commit_done, 1);
                chk("lat.ep_old", ep_ctrl, m_active);
            end
            tick();
        end
        m_active = shadow_image();
        exp99 = {1'b1, 2'b11, 48'h1FFF, 48'h1000};
        chk("lat.ep0", ep_ctrl[98:0], exp99);
        chk("lat.ep_ctrl", ep_ctrl, m_active);
        chk("lat.after", {commit_done, busy, hold, cfg_err}, 0);
        $display("[TB] latency commit: ep_ctrl[98:0]=%0h", ep_ctrl[98:0]);

        for (int i = 0; i < 12; i++) begin
            prog(vecs[i].ep, vecs[i].base, vecs[i].bound, vecs[i].acc, vecs[i].val);
            commit_run($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_ep);
        end

        // Drain with three requests completing 5 cycles apart.
        req_issue = 1'b1;
        repeat (3) tick();
        req_issue = 1'b0;
        chk("drain.count", outstanding, 3);
        cmd_commit = 1'b1;
        tick();
        cmd_commit = 1'b0;
        for (int j = 0; j < 3; j++) begin
            req_done = 1'b1;
            tick();
            req_done = 1'b0;
            if (j < 2) begin
                for (int k = 0; k < 4; k++) begin
                    chk("drain.hold", hold, 1);
                    tick();
                end
            end
        end
        chk("drain.zero", outstanding, 0);
        chk("drain.hold_last", hold, 1);
        cyc = 0;
        while (commit_done !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("drain.validate_delay", cyc, N + 1);
        tick();
        m_active = shadow_image();
        chk("drain.ok", {cfg_err, busy, hold}, 0);
        chk("drain.ep_ctrl", ep_ctrl, m_active);
        $display("[TB] drain commit: done %0d cycles after count hit 0", cyc);

        // Drain timeout with one request stuck.
        req_issue = 1'b1;
        tick();
        req_issue = 1'b0;
        prog(1, 48'h7000, 48'h7FFF, 2'b10, 1'b1);
        cmd_commit = 1'b1;
        tick();
        cmd_commit = 1'b0;
        cyc = 1;
        while (commit_done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("tmo.cycle", cyc, DT + 1);
        tick();
        chk("tmo.hold", {busy, hold}, 0);
        chk("tmo.err", {cfg_err, err_code, err_ep}, {1'b1, 2'b10, 3'b111});
        chk("tmo.ep_ctrl", ep_ctrl, m_active);
        $display("[TB] timeout commit: done at cycle %0d err_code=%0d", cyc, err_code);
        req_done = 1'b1;
        tick();
        req_done = 1'b0;
        commit_run("tmo.clean", 1'b0, 2'b00, 3'd0);

        // Write while busy is rejected and leaves the shadow alone.
        req_issue = 1'b1;
        tick();
        req_issue = 1'b0;
        cmd_commit = 1'b1;
        tick();
        cmd_commit = 1'b0;
        wr(0, 32'hDEAD_BEEF);
        chk("rej.pulse", cfg_wr_rej, 1);
        tick();
        chk("rej.single", cfg_wr_rej, 0);
        req_done = 1'b1;
        tick();
        req_done = 1'b0;
        wait_done("rej", cyc);
        tick();
        m_active = shadow_image();
        chk("rej.ep_ctrl", ep_ctrl, m_active);
        chk("rej.err", cfg_err, 0);
        $display("[TB] busy write: ep0 base=%0h", ep_ctrl[47:0]);

        // Counter corner cases.
        req_issue = 1'b1;
        repeat (2) tick();
        req_done = 1'b1;
        tick();
        chk("cnt.both", outstanding, 2);
        req_issue = 1'b0;
        repeat (3) tick();
        req_done = 1'b0;
        chk("cnt.floor", outstanding, 0);
        req_issue = 1'b1;
        repeat (260) tick();
        chk("cnt.ceiling", outstanding, 255);
        req_done = 1'b1;
        tick();
        chk("cnt.both_sat", outstanding, 255);
        req_issue = 1'b0;
        tick();
        chk("cnt.dec", outstanding, 254);
        repeat (260) tick();
        req_done = 1'b0;
        chk("cnt.model", outstanding, OB'(m_out));
        $display("[TB] counter corners: final count=%0d", outstanding);

        // Reset in VALIDATE aborts without a commit_done pulse.
        prog(1, 48'hA000, 48'hAFFF, 2'b01, 1'b1);
        cmd_commit = 1'b1;
        tick();
        cmd_commit = 1'b0;
        tick();
        aresetn = 1'b0;
        tick();
        model_reset();
        chk_zero("rst_mid");
        tick();
        aresetn = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen = seen | commit_done;
        end
        chk("rst_mid.no_done", seen, 0);
        prog(0, 48'h1000, 48'h1FFF, 2'b11, 1'b1);
        commit_run("rst_mid.fresh", 1'b0, 2'b00, 3'd0);
        chk("rst_mid.ep0", ep_ctrl[98:0], exp99);

        // Randomized traffic, table updates and commits.
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(3, 12)) begin
                req_issue = 1'($urandom());
                req_done  = 1'($urandom());
                tick();
            end
            req_issue = 1'b0;
            req_done  = 1'b0;
            chk($sformatf("rnd%0d.count", it), outstanding, OB'(m_out));
            repeat ($urandom_range(1, 3)) begin
                r = {$urandom(), $urandom()};
                b = r[47:0];
                d = 48'($urandom_range(0, 3));
                prog($urandom_range(0, N - 1), b, ($urandom() % 2 == 0) ? b + d : b - d,
                     2'($urandom()), 1'($urandom()));
            end
            if ($urandom() % 3 != 0) begin
                req_done = 1'b1;
                while (m_out > 0) tick();
                req_done = 1'b0;
            end
            predict(pe, pc, pep);
            commit_run($sformatf("rnd%0d", it), pe, pc, pep);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
